// File: rtl/a500_autoconfig_ctrl.sv
// rtl/a500_autoconfig_ctrl.sv - Zorro II AUTOCONFIG responder for the A500 8MB FastRAM board.
// Optional CFGOUT_EN adds registered /CFGOUT (cfg_out_n) for daisy-chaining.
module a500_autoconfig_ctrl #(
  parameter logic [2:0]  ER_SIZE    = 3'b000,
  parameter logic [7:0]  PRODUCT_ID = 8'h10,
  parameter logic [15:0] MANUF_ID   = 16'h07DB
) (
  input  logic       cpu_clk,
  input  logic       cpu_reset,
  input  logic       cpu_as,
  input  logic       cpu_uds,
  input  logic       cpu_lds,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_addr_hi,
  input  logic [5:0] cpu_addr_lo,
  input  logic [3:0] cpu_d_in,
  output logic [3:0] cpu_d_out,
  output logic       cpu_d_oe,
  output logic [7:0] base_addr,
  output logic       mem_enable,
  output logic       autoconf_busy
`ifdef CFGOUT_EN
  ,
  output logic       cfg_out_n
`endif
);

  typedef enum logic [1:0] {UNCONF, CONFIG, SHUTUP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  base_q, base_d;
  logic [3:0]  lo_pend_q, lo_pend_d;
  logic [3:0]  d_out_q, d_out_d;
  logic        rd_act_q, rd_act_d;
  logic        as_z_q;

  logic        start;
  logic        hit;
  logic        lds_only;
  logic        wr_lane;
  logic [3:0]  rom_nibble;
  logic [7:0]  product_n;
  logic [15:0] manuf_n;

  assign product_n = ~PRODUCT_ID;
  assign manuf_n   = ~MANUF_ID;

  // Register nibbles live on D15..D12, so an LDS-only (odd byte) strobe never carries them.
  assign lds_only = cpu_uds & ~cpu_lds;
  assign wr_lane  = ~cpu_uds & ~lds_only;

  assign start = ~cpu_as & as_z_q;
  assign hit   = (cpu_addr_hi == 8'hE8) && (state_q == UNCONF);

  always_comb begin
    rom_nibble = 4'hF;
    case (cpu_addr_lo)
      6'h00:        rom_nibble = 4'hE;
      6'h01:        rom_nibble = {1'b0, ER_SIZE};
      6'h02:        rom_nibble = product_n[7:4];
      6'h03:        rom_nibble = product_n[3:0];
      6'h08:        rom_nibble = manuf_n[15:12];
      6'h09:        rom_nibble = manuf_n[11:8];
      6'h0A:        rom_nibble = manuf_n[7:4];
      6'h0B:        rom_nibble = manuf_n[3:0];
      6'h20, 6'h21: rom_nibble = 4'h0;
      default:      rom_nibble = 4'hF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    lo_pend_d = lo_pend_q;
    rd_act_d  = rd_act_q;
    d_out_d   = d_out_q;

    if (start && hit && cpu_rw) begin
      rd_act_d = 1'b1;
      d_out_d  = rom_nibble;
    end else if (cpu_as) begin
      rd_act_d = 1'b0;
      d_out_d  = 4'hF;
    end

    if (start && hit && !cpu_rw && wr_lane) begin
      case (cpu_addr_lo)
        6'h25: lo_pend_d = cpu_d_in;
        6'h24: begin
          base_d  = {cpu_d_in, lo_pend_q};
          state_d = CONFIG;
        end
        6'h26: state_d = SHUTUP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state_q   <= UNCONF;
      base_q    <= 8'h00;
      lo_pend_q <= 4'h0;
      d_out_q   <= 4'hF;
      rd_act_q  <= 1'b0;
      as_z_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      lo_pend_q <= lo_pend_d;
      d_out_q   <= d_out_d;
      rd_act_q  <= rd_act_d;
      as_z_q    <= cpu_as;
    end
  end

  // Drive is released combinationally the moment /AS rises, not on the next edge.
  assign cpu_d_oe      = rd_act_q & ~cpu_as;
  assign cpu_d_out     = d_out_q;
  assign base_addr     = base_q;
  assign mem_enable    = (state_q == CONFIG);
  assign autoconf_busy = (state_q == UNCONF);

`ifdef CFGOUT_EN
  logic cfg_out_n_q;

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      cfg_out_n_q <= 1'b1;
    end else begin
      cfg_out_n_q <= (state_q == UNCONF);
    end
  end

  assign cfg_out_n = cfg_out_n_q;
`endif

endmodule

// File: tb/tb_a500_autoconfig_ctrl.sv
// tb/tb_a500_autoconfig_ctrl.sv - self-checking bench for a500_autoconfig_ctrl (optional CFGOUT_EN).
module tb_a500_autoconfig_ctrl;
  localparam logic [2:0]  ER  = 3'b000;
  localparam logic [7:0]  PID = 8'h10;
  localparam logic [15:0] MID = 16'h07DB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [7:0] ahi = 8'h00;
  logic [5:0] alo = 6'h00;
  logic [3:0] din = 4'h0;
  wire  [3:0] dout;
  wire        oe;
  wire  [7:0] base;
  wire        men, busy;
`ifdef CFGOUT_EN
  wire        cfgn;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  a500_autoconfig_ctrl #(.ER_SIZE(ER), .PRODUCT_ID(PID), .MANUF_ID(MID)) dut (
    .cpu_clk(clk), .cpu_reset(rst), .cpu_as(as_n), .cpu_uds(uds_n), .cpu_lds(lds_n),
    .cpu_rw(rw), .cpu_addr_hi(ahi), .cpu_addr_lo(alo), .cpu_d_in(din),
    .cpu_d_out(dout), .cpu_d_oe(oe), .base_addr(base), .mem_enable(men),
    .autoconf_busy(busy)
`ifdef CFGOUT_EN
    , .cfg_out_n(cfgn)
`endif
  );

  // Expansion ROM contents indexed by byte offset within $E8xxxx.
  function automatic logic [3:0] rom_at(input int off);
    logic [7:0]  p;
    logic [15:0] m;
    p = ~PID;
    m = ~MID;
    case (off)
      'h00: return 4'hE;
      'h02: return {1'b0, ER};
      'h04: return p[7:4];
      'h06: return p[3:0];
      'h10: return m[15:12];
      'h12: return m[11:8];
      'h14: return m[7:4];
      'h16: return m[3:0];
      'h40, 'h42: return 4'h0;
      default: return 4'hF;
    endcase
  endfunction

  bit         m_cfg, m_shut, m_rd, m_asp, m_cfgn;
  logic [7:0] m_base;
  logic [3:0] m_lo, m_nib;
  bit         m_st, m_hit;
  int         m_off;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cfg <= 0; m_shut <= 0; m_rd <= 0; m_asp <= 1; m_cfgn <= 1;
      m_base <= 8'h00; m_lo <= 4'h0; m_nib <= 4'hF;
    end else begin
      m_st  = !as_n && m_asp;
      m_hit = (ahi == 8'hE8) && !m_cfg && !m_shut;
      m_off = int'(alo) * 2;
      m_asp  <= as_n;
      m_cfgn <= !(m_cfg || m_shut);
      if (m_st && m_hit && rw) begin
        m_rd <= 1; m_nib <= rom_at(m_off);
      end else if (as_n) begin
        m_rd <= 0;
      end
      if (m_st && m_hit && !rw && !uds_n) begin
        if (m_off == 'h4A) m_lo <= din;
        else if (m_off == 'h48) begin m_base <= {din, m_lo}; m_cfg <= 1; end
        else if (m_off == 'h4C) m_shut <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("oe_model",   32'(oe),   32'(m_rd && !as_n));
    chk("dout_model", 32'(dout), 32'(m_rd ? m_nib : 4'hF));
    chk("base_model", 32'(base), 32'(m_base));
    chk("men_model",  32'(men),  32'(m_cfg));
    chk("busy_model", 32'(busy), 32'(!(m_cfg || m_shut)));
`ifdef CFGOUT_EN
    chk("cfgn_model", 32'(cfgn), 32'(m_cfgn));
`endif
  end

  // One full bus cycle; samples data mid-cycle and oe just after /AS rises.
  task automatic bus(input logic [7:0] hi, input logic [5:0] lo, input bit r, input logic [3:0] d,
                     input bit u, input bit l, output logic [3:0] sd, output logic so,
                     output logic so_after);
    @(posedge clk); #2;
    ahi = hi; alo = lo; rw = r; din = d; as_n = 0; uds_n = !u; lds_n = !l;
    @(posedge clk); @(posedge clk); #3;
    sd = dout; so = oe;
    @(posedge clk); #2;
    as_n = 1; uds_n = 1; lds_n = 1; rw = 1;
    #1 so_after = oe;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1; as_n = 1; uds_n = 1; lds_n = 1; rw = 1;
    @(posedge clk); #2;
    rst = 0;
  endtask

  logic [3:0] sd;
  logic       so, sa;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("rst_base", 32'(base), 32'h00);
    chk("rst_men",  32'(men),  32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_oe",   32'(oe),   32'h0);
    chk("rst_dout", 32'(dout), 32'hF);

    bus(8'hE8, 6'h00, 1, 4'h0, 1, 1, sd, so, sa);
    chk("rd00_d", 32'(sd), 32'hE); chk("rd00_oe", 32'(so), 32'h1); chk("rd00_oe_off", 32'(sa), 32'h0);
    bus(8'hE8, 6'h01, 1, 4'h0, 1, 1, sd, so, sa);
    chk("rd02_d", 32'(sd), 32'h0);
    bus(8'hE8, 6'h02, 1, 4'h0, 1, 1, sd, so, sa);
    chk("rd04_d", 32'(sd), 32'hE);
    bus(8'hE8, 6'h03, 1, 4'h0, 1, 1, sd, so, sa);
    chk("rd06_d", 32'(sd), 32'hF);
    bus(8'hE8, 6'h09, 1, 4'h0, 1, 1, sd, so, sa);
    chk("rd12_d", 32'(sd), 32'h8);
    bus(8'hE8, 6'h21, 1, 4'h0, 1, 1, sd, so, sa);
    chk("rd42_d", 32'(sd), 32'h0);
    bus(8'hE8, 6'h1F, 1, 4'h0, 1, 1, sd, so, sa);
    chk("rd3e_d", 32'(sd), 32'hF);
    bus(8'h20, 6'h00, 1, 4'h0, 1, 1, sd, so, sa);
    chk("rd_miss_oe", 32'(so), 32'h0);

    bus(8'hE8, 6'h25, 0, 4'h0, 1, 1, sd, so, sa);
    bus(8'hE8, 6'h24, 0, 4'h2, 1, 1, sd, so, sa);
    chk("cfg_wr_oe", 32'(so), 32'h0);
    chk("cfg_base", 32'(base), 32'h20);
    chk("cfg_men",  32'(men),  32'h1);
    chk("cfg_busy", 32'(busy), 32'h0);
    bus(8'hE8, 6'h00, 1, 4'h0, 1, 1, sd, so, sa);
    chk("post_cfg_oe", 32'(so), 32'h0);
    bus(8'hE8, 6'h24, 0, 4'h4, 1, 1, sd, so, sa);
    chk("post_cfg_base", 32'(base), 32'h20);

    do_reset();
    bus(8'hE8, 6'h25, 0, 4'h9, 0, 1, sd, so, sa);
    bus(8'hE8, 6'h25, 0, 4'h7, 1, 1, sd, so, sa);
    bus(8'hE8, 6'h24, 0, 4'h3, 0, 1, sd, so, sa);
    chk("lds_only_busy", 32'(busy), 32'h1);
    bus(8'hC8, 6'h24, 0, 4'h3, 1, 1, sd, so, sa);
    chk("c8_busy", 32'(busy), 32'h1);
    bus(8'hE8, 6'h24, 0, 4'h3, 1, 1, sd, so, sa);
    chk("lo_pend_base", 32'(base), 32'h37);

    do_reset();
    bus(8'hE8, 6'h26, 0, 4'h0, 1, 1, sd, so, sa);
    @(posedge clk); #3;
    chk("shut_men",  32'(men),  32'h0);
    chk("shut_busy", 32'(busy), 32'h0);
`ifdef CFGOUT_EN
    chk("shut_cfgn", 32'(cfgn), 32'h0);
`endif
    bus(8'hE8, 6'h00, 1, 4'h0, 1, 1, sd, so, sa);
    chk("shut_rd_oe", 32'(so), 32'h0);

    do_reset();
    bus(8'hE8, 6'h25, 0, 4'h6, 1, 1, sd, so, sa);
    @(posedge clk); #2;
    ahi = 8'hE8; alo = 6'h00; rw = 1; as_n = 0; uds_n = 0; lds_n = 0;
    @(posedge clk); @(posedge clk); #3;
    chk("midrd_oe_pre", 32'(oe), 32'h1);
    rst = 1;
    #1;
    chk("midrd_oe",   32'(oe),   32'h0);
    chk("midrd_busy", 32'(busy), 32'h1);
    chk("midrd_base", 32'(base), 32'h00);
    as_n = 1; uds_n = 1; lds_n = 1;
    @(posedge clk); #2 rst = 0;
    bus(8'hE8, 6'h24, 0, 4'h3, 1, 1, sd, so, sa);
    chk("midrd_lo_cleared", 32'(base), 32'h30);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
